data_memory_bus: RTL



---
 rtl/data_memory_bus.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_bus.sv
// ---------------------------------------------------------------------------
// data_memory_bus
// Handshaked data memory for the pipelined MIPS core. Supports byte, halfword
// and word loads/stores with byte-lane merging, sign/zero-extended loads and a
// programmable number of wait states so the MEM stage has to stall.
//
// Parameters
//    ADDR_W       byte-address width, depth = 2**(ADDR_W-2) words
//    WAIT_CYCLES  extra cycles between accept and access (0..15)
//
// Ports
//    clk          single clock, rising edge
//    rst_n        asynchronous active-low reset
//    req_valid    request present
//    req_ready    block can accept a request
//    req_write    1 = store, 0 = load
//    req_addr     byte address
//    req_size     00 byte, 01 half, 10 word, 11 reserved
//    req_signed   sign-extend load result
//    req_wdata    store data (low-order bits)
//    resp_valid   one-cycle response pulse
//    resp_rdata   extended load data, 0 for stores and errors
//    resp_err     reserved size or trapped misalignment
//
// Configuration macro: DMEM_MISALIGN_TRAP_EN
//    defined   -> misaligned half/word accesses error out without a write
//    undefined -> misaligned low address bits are ignored
// ---------------------------------------------------------------------------
module data_memory_bus #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int DEPTH = 2 ** (ADDR_W - 2);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [31:0]       r_wdata;
   logic [31:0]       r_respRdata;
   logic              r_respErr;
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept;
   logic              w_access;
   logic [1:0]        w_offset;
   logic              w_misalign;
   logic              w_err;
   logic [31:0]       w_word;
   logic [31:0]       w_shifted;
   logic [31:0]       w_loadData;
   logic [3:0]        w_byteEn;
   logic [31:0]       w_laneData;
   logic [31:0]       w_merged;

   assign w_accept = (r_state == IDLE) && req_valid;
   assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: one request in flight, no overlap
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE:    if (req_valid) w_nextState = WAIT;
         WAIT:    if (r_cnt == 4'd0) w_nextState = RESP;
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Outputs decoded from state; ready is held low while reset is asserted
   always_comb begin
      req_ready  = (r_state == IDLE) && rst_n;
      resp_valid = (r_state == RESP);
   end

   // Request capture and wait-state countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= 4'd0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_wdata  <= 32'd0;
      end else if (w_accept) begin
         r_cnt    <= 4'(WAIT_CYCLES);
         r_write  <= req_write;
         r_addr   <= req_addr;
         r_size   <= req_size;
         r_signed <= req_signed;
         r_wdata  <= req_wdata;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Lane selection: misaligned low bits are dropped down to the natural
   // alignment of the access size
   always_comb begin
      w_offset   = 2'b00;
      w_byteEn   = 4'b0000;
      w_laneData = r_wdata;
      unique case (r_size)
         2'b00: begin
            w_offset   = r_addr[1:0];
            w_byteEn   = 4'b0001 << r_addr[1:0];
            w_laneData = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_offset   = {r_addr[1], 1'b0};
            w_byteEn   = 4'b0011 << {r_addr[1], 1'b0};
            w_laneData = {2{r_wdata[15:0]}};
         end
         2'b10: begin
            w_byteEn = 4'b1111;
         end
         default: begin
            w_byteEn = 4'b0000;
         end
      endcase
   end

   assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                       ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_err = (r_size == 2'b11) || w_misalign;
`else
   assign w_err = (r_size == 2'b11);
`endif

   assign w_word    = r_mem[r_addr[ADDR_W-1:2]];
   assign w_shifted = w_word >> {w_offset, 3'b000};

   // Load extension and store read-modify-write merge
   always_comb begin
      w_loadData = w_shifted;
      unique case (r_size)
         2'b00:   w_loadData = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_loadData = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
         default: w_loadData = w_shifted;
      endcase
      for (int i = 0; i < 4; i++) begin
         w_merged[8*i +: 8] = w_byteEn[i] ? w_laneData[8*i +: 8] : w_word[8*i +: 8];
      end
   end

   // Storage is deliberately not reset; a dropped request never reaches
   // the commit edge because reset forces the state back to IDLE
   always_ff @(posedge clk) begin
      if (w_access && r_write && !w_err && !w_misalign_unused_guard()) begin
         r_mem[r_addr[ADDR_W-1:2]] <= w_merged;
      end
   end

   function automatic logic w_misalign_unused_guard();
      return 1'b0;
   endfunction

   // Response registers, loaded on the access edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_respRdata <= 32'd0;
         r_respErr   <= 1'b0;
      end else if (w_access) begin
         r_respRdata <= (r_write || w_err) ? 32'd0 : w_loadData;
         r_respErr   <= w_err;
      end
   end

   assign resp_rdata = r_respRdata;
   assign resp_err   = r_respErr;

endmodule
